// File: rtl/parity_pkg.sv
// Shared parity helpers for receive-side checkers and drive-side parity generators.
package parity_pkg;

  localparam int MAX_GRAN = 64;

  function automatic int calc_p(input int data_w, input int gran);
    return data_w / gran;
  endfunction

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic bit gran_ok(input int data_w, input int gran);
    return (gran > 0) && (gran <= MAX_GRAN) && ((data_w % gran) == 0);
  endfunction

  // Lanes narrower than MAX_GRAN are zero-extended, which leaves the XOR unchanged.
  function automatic logic lane_parity(input logic [MAX_GRAN-1:0] lane, input logic odd);
    return (^lane) ^ odd;
  endfunction

endpackage

// File: rtl/parity_chk_array_if.sv
// Snooped channel handshakes plus the checker's sticky error reporting.
interface parity_chk_array_if
  import parity_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int GRAN   = 8,
  parameter int CNT_W  = 8
);
  localparam int P    = calc_p(DATA_W, GRAN);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0]        CH_VALID;
  logic [NUM_CH-1:0]        CH_READY;
  logic [NUM_CH*DATA_W-1:0] CH_DATA;
  logic [NUM_CH*P-1:0]      CH_PARITY;
  logic [NUM_CH-1:0]        ENERR;
  logic [NUM_CH-1:0]        FIERR;
  logic                     ERR_CLR;
  logic                     ERR;
  logic                     ERR_B;
  logic [NUM_CH-1:0]        ERR_VEC;
  logic [CH_W-1:0]          ERR_CH;
  logic [CNT_W-1:0]         ERR_CNT;

  modport master (
    output CH_VALID, CH_READY, CH_DATA, CH_PARITY, ENERR, FIERR, ERR_CLR,
    input  ERR, ERR_B, ERR_VEC, ERR_CH, ERR_CNT
  );

  modport slave (
    input  CH_VALID, CH_READY, CH_DATA, CH_PARITY, ENERR, FIERR, ERR_CLR,
    output ERR, ERR_B, ERR_VEC, ERR_CH, ERR_CNT
  );

endinterface

// File: rtl/parity_lane_chk.sv
// One channel: registers the snooped beat, recomputes lane parity and flags a mismatch.
module parity_lane_chk
  import parity_pkg::*;
#(
  parameter int  DATA_W = 64,
  parameter int  GRAN   = 8,
  parameter int  ODD    = 0,
  localparam int P      = calc_p(DATA_W, GRAN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              ready,
  input  logic              enerr,
  input  logic              fierr,
  input  logic [DATA_W-1:0] data,
  input  logic [P-1:0]      parity,
  output logic              fail
);

  logic              vld_p1;
  logic              fi_p1;
  logic [DATA_W-1:0] data_p1;
  logic [P-1:0]      par_p1;
  logic [P-1:0]      exp_par;
  logic [P-1:0]      rx_par;

  // Stage 1: capture the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      fi_p1   <= 1'b0;
      data_p1 <= '0;
      par_p1  <= '0;
    end else begin
      vld_p1 <= valid & ready & enerr;
      fi_p1  <= fierr & valid & ready;
      if (valid & ready) begin
        data_p1 <= data;
        par_p1  <= parity;
      end
    end
  end

  // Compare: injection corrupts only lane 0 of the received parity
  always_comb begin
    exp_par = '0;
    for (int l = 0; l < P; l++) begin
      exp_par[l] = lane_parity(MAX_GRAN'(data_p1[l*GRAN +: GRAN]), ODD != 0);
    end
    rx_par    = par_p1;
    rx_par[0] = par_p1[0] ^ fi_p1;
  end

  assign fail = vld_p1 & (exp_par != rx_par);

endmodule

// File: rtl/parity_chk_array.sv
// Shared receive parity checker: per-channel lane checks feed sticky flags, first-channel and count.
module parity_chk_array
  import parity_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int GRAN   = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input logic                 ACLK,
  input logic                 RESETN_ACLK,
  parity_chk_array_if.slave   bus
);

  localparam int P    = calc_p(DATA_W, GRAN);
  localparam int CH_W = ch_idx_w(NUM_CH);
  localparam int PC_W = 5;

  if (!gran_ok(DATA_W, GRAN)) begin : g_gran_chk
    $error("parity_chk_array: DATA_W must be a positive multiple of GRAN");
  end

  logic [NUM_CH-1:0] fail;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    parity_lane_chk #(
      .DATA_W (DATA_W),
      .GRAN   (GRAN),
      .ODD    (ODD)
    ) u_lane (
      .clk    (ACLK),
      .rst_n  (RESETN_ACLK),
      .valid  (bus.CH_VALID[c]),
      .ready  (bus.CH_READY[c]),
      .enerr  (bus.ENERR[c]),
      .fierr  (bus.FIERR[c]),
      .data   (bus.CH_DATA[c*DATA_W +: DATA_W]),
      .parity (bus.CH_PARITY[c*P +: P]),
      .fail   (fail[c])
    );
  end

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_CH-1:0] f);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + PC_W'(f[i]);
    return n;
  endfunction

  function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] f);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (f[i]) idx = i[CH_W-1:0];
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [CNT_W+PC_W-1:0] s;
    s = {{PC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
    if (s > {{PC_W{1'b0}}, {CNT_W{1'b1}}}) return '1;
    return s[CNT_W-1:0];
  endfunction

  logic [NUM_CH-1:0] err_vec, vec_base, vec_nxt;
  logic [CNT_W-1:0]  err_cnt, cnt_nxt;
  logic [CH_W-1:0]   err_ch, ch_nxt;
  logic              err, err_b;

  // A clear in the same cycle as a failure wipes old state before latching the new one
  always_comb begin
    vec_base = bus.ERR_CLR ? '0 : err_vec;
    vec_nxt  = vec_base | fail;
    cnt_nxt  = sat_add(bus.ERR_CLR ? '0 : err_cnt, popcount(fail));
    ch_nxt   = err_ch;
    if (vec_base == '0) ch_nxt = lowest_idx(fail);
  end

  // Stage 2: sticky reporting
  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      err_vec <= '0;
      err_cnt <= '0;
      err_ch  <= '0;
      err     <= 1'b0;
      err_b   <= 1'b1;
    end else begin
      err_vec <= vec_nxt;
      err_cnt <= cnt_nxt;
      err_ch  <= ch_nxt;
      err     <= |vec_nxt;
      err_b   <= ~(|vec_nxt);
    end
  end

  assign bus.ERR     = err;
  assign bus.ERR_B   = err_b;
  assign bus.ERR_VEC = err_vec;
  assign bus.ERR_CH  = err_ch;
  assign bus.ERR_CNT = err_cnt;

endmodule

// File: tb/tb_parity_chk_array.sv
// Directed checks of parity_chk_array: default build plus an odd-parity, 2-bit-counter build.
module tb_parity_chk_array;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  parity_chk_array_if #(.NUM_CH(4), .DATA_W(64), .GRAN(8), .CNT_W(8)) bus0 ();
  parity_chk_array_if #(.NUM_CH(4), .DATA_W(64), .GRAN(8), .CNT_W(2)) bus1 ();

  parity_chk_array #(.NUM_CH(4), .DATA_W(64), .GRAN(8), .ODD(0), .CNT_W(8)) dut0 (
    .ACLK        (clk),
    .RESETN_ACLK (rstn),
    .bus         (bus0.slave)
  );

  parity_chk_array #(.NUM_CH(4), .DATA_W(64), .GRAN(8), .ODD(1), .CNT_W(2)) dut1 (
    .ACLK        (clk),
    .RESETN_ACLK (rstn),
    .bus         (bus1.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input int c, input logic [63:0] d, input logic [7:0] p);
    bus0.CH_DATA[c*64 +: 64] = d;
    bus0.CH_PARITY[c*8 +: 8] = p;
  endtask

  task automatic drive1(input int c, input logic [63:0] d, input logic [7:0] p);
    bus1.CH_DATA[c*64 +: 64] = d;
    bus1.CH_PARITY[c*8 +: 8] = p;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_err"},   64'(bus0.ERR),     64'd0);
    chk({tag, "_err_b"}, 64'(bus0.ERR_B),   64'd1);
    chk({tag, "_vec"},   64'(bus0.ERR_VEC), 64'd0);
    chk({tag, "_ch"},    64'(bus0.ERR_CH),  64'd0);
    chk({tag, "_cnt"},   64'(bus0.ERR_CNT), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] cafe_par [5] = '{8'h04, 8'h06, 8'h06, 8'h04, 8'h06};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rstn = 1'b0;
    bus0.CH_VALID = '0; bus0.CH_READY = 4'hF; bus0.CH_DATA = '0; bus0.CH_PARITY = '0;
    bus0.ENERR = '0; bus0.FIERR = '0; bus0.ERR_CLR = 1'b0;
    bus1.CH_VALID = '0; bus1.CH_READY = 4'hF; bus1.CH_DATA = '0; bus1.CH_PARITY = '0;
    bus1.ENERR = '0; bus1.FIERR = '0; bus1.ERR_CLR = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk_reset0("reset");
    rstn = 1'b1;

    // Disabled channel 0 with wrong parity: ignored
    bus0.ENERR = 4'b1110;
    drive0(0, 64'h0000_0000_DEAD_0000, 8'h00);
    bus0.CH_VALID = 4'b0001;
    tick();
    bus0.CH_VALID = '0;
    tick();
    chk("enerr0_err", 64'(bus0.ERR), 64'd0);
    chk("enerr0_cnt", 64'(bus0.ERR_CNT), 64'd0);

    // Back-to-back correct beats on channel 1
    bus0.ENERR = 4'hF;
    for (int i = 0; i < 5; i++) begin
      drive0(1, 64'hCAFE_0000 + (64'(i) << 8), cafe_par[i]);
      bus0.CH_VALID = 4'b0010;
      tick();
      chk("b2b_err", 64'(bus0.ERR), 64'd0);
    end
    bus0.CH_VALID = '0;
    tick();
    chk("b2b_err_end", 64'(bus0.ERR), 64'd0);
    chk("b2b_cnt_end", 64'(bus0.ERR_CNT), 64'd0);

    // Fault injection on channel 2 with otherwise correct parity
    drive0(2, 64'hBEEF_0000, 8'h04);
    bus0.CH_VALID = 4'b0100;
    bus0.FIERR    = 4'b0100;
    tick();
    bus0.CH_VALID = '0;
    bus0.FIERR    = '0;
    chk("fi_latency", 64'(bus0.ERR), 64'd0);
    tick();
    chk("fi_err",   64'(bus0.ERR),     64'd1);
    chk("fi_err_b", 64'(bus0.ERR_B),   64'd0);
    chk("fi_vec",   64'(bus0.ERR_VEC), 64'h4);
    chk("fi_ch",    64'(bus0.ERR_CH),  64'd2);
    chk("fi_cnt",   64'(bus0.ERR_CNT), 64'd1);
    bus0.FIERR = 4'hF;
    tick();
    tick();
    bus0.FIERR = '0;
    chk("fi_nobeat_cnt", 64'(bus0.ERR_CNT), 64'd1);
    chk("fi_nobeat_vec", 64'(bus0.ERR_VEC), 64'h4);

    // Asynchronous reset while errors are latched
    rstn = 1'b0;
    #2;
    chk_reset0("midreset");
    tick();
    rstn = 1'b1;

    // Simultaneous failures on channels 1 and 3
    drive0(1, 64'h0, 8'h01);
    drive0(3, 64'h0, 8'h01);
    bus0.CH_VALID = 4'b1010;
    tick();
    bus0.CH_VALID = '0;
    tick();
    chk("dual_cnt", 64'(bus0.ERR_CNT), 64'd2);
    chk("dual_ch",  64'(bus0.ERR_CH),  64'd1);
    chk("dual_vec", 64'(bus0.ERR_VEC), 64'hA);

    // Clear coinciding with a fresh channel-0 failure
    drive0(0, 64'h0, 8'h01);
    bus0.CH_VALID = 4'b0001;
    tick();
    bus0.CH_VALID = '0;
    bus0.ERR_CLR  = 1'b1;
    tick();
    bus0.ERR_CLR  = 1'b0;
    chk("clrfail_vec", 64'(bus0.ERR_VEC), 64'h1);
    chk("clrfail_ch",  64'(bus0.ERR_CH),  64'd0);
    chk("clrfail_cnt", 64'(bus0.ERR_CNT), 64'd1);
    chk("clrfail_err", 64'(bus0.ERR),     64'd1);

    bus0.ERR_CLR = 1'b1;
    tick();
    bus0.ERR_CLR = 1'b0;
    chk("clr_err",   64'(bus0.ERR),     64'd0);
    chk("clr_err_b", 64'(bus0.ERR_B),   64'd1);
    chk("clr_cnt",   64'(bus0.ERR_CNT), 64'd0);

    // Reset between capture and report drops the failing beat
    drive0(2, 64'h0, 8'h01);
    bus0.CH_VALID = 4'b0100;
    tick();
    bus0.CH_VALID = '0;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
    chk("dropbeat_err", 64'(bus0.ERR),     64'd0);
    chk("dropbeat_vec", 64'(bus0.ERR_VEC), 64'd0);
    chk("dropbeat_cnt", 64'(bus0.ERR_CNT), 64'd0);

    // Odd parity build: all-ones parity on zero data passes
    bus1.ENERR = 4'hF;
    drive1(0, 64'h0, 8'hFF);
    bus1.CH_VALID = 4'b0001;
    tick();
    bus1.CH_VALID = '0;
    tick();
    chk("odd_pass_err", 64'(bus1.ERR),     64'd0);
    chk("odd_pass_cnt", 64'(bus1.ERR_CNT), 64'd0);

    // Six failing beats saturate the 2-bit counter
    drive1(0, 64'h0, 8'h00);
    bus1.CH_VALID = 4'b0001;
    tick();
    tick();
    chk("odd_cnt_one", 64'(bus1.ERR_CNT), 64'd1);
    repeat (4) tick();
    bus1.CH_VALID = '0;
    tick();
    chk("odd_sat_cnt", 64'(bus1.ERR_CNT), 64'd3);
    chk("odd_sat_err", 64'(bus1.ERR),     64'd1);
    chk("odd_sat_vec", 64'(bus1.ERR_VEC), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
